// File: rtl/histogram_calc.sv
// Per-frame intensity histogram: clear, 2-stage RMW accumulate, flush, then ordered bin readout.
// Bin readout has 1-cycle latency from rd_en_i_hist; pixels are taken only while ready_o_hist is high.
module histogram_calc #(
   parameter int DATA_WIDTH  = 8,
   parameter int RAM_DEPTH   = 76800,
   parameter int BIN_COUNT   = 2**DATA_WIDTH,
   parameter int COUNT_WIDTH = $clog2(RAM_DEPTH+1)
) (
   input  logic                   clk_i_hist,
   input  logic                   rstn_i_hist,
   input  logic                   en_i_hist,
   input  logic                   valid_i_hist,
   input  logic [DATA_WIDTH-1:0]  data_i_hist,
   input  logic                   rd_en_i_hist,
   output logic                   ready_o_hist,
   output logic                   busy_o_hist,
   output logic [DATA_WIDTH-1:0]  bin_o_hist,
   output logic [COUNT_WIDTH-1:0] count_o_hist,
   output logic                   valid_o_hist,
   output logic                   done_o_hist
);

   localparam logic [DATA_WIDTH-1:0]  LAST_BIN = DATA_WIDTH'(BIN_COUNT-1);
   localparam logic [COUNT_WIDTH-1:0] LAST_PIX = COUNT_WIDTH'(RAM_DEPTH-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_FLUSH,
      S_READOUT
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  clr_ptr_q, clr_ptr_d;
   logic [COUNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
   logic                   flush_cnt_q, flush_cnt_d;
   logic [DATA_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic                   rd_last_q, rd_last_d;

   logic                   s1_vld_q;
   logic [DATA_WIDTH-1:0]  s1_addr_q;
   logic                   s2_vld_q;
   logic [DATA_WIDTH-1:0]  s2_addr_q;
   logic [COUNT_WIDTH-1:0] s2_cnt_q;

   logic [COUNT_WIDTH-1:0] bin_mem_q [BIN_COUNT];
   logic [COUNT_WIDTH-1:0] mem_rdata_q;

   logic                   out_vld_q;
   logic                   done_q;
   logic [DATA_WIDTH-1:0]  out_bin_q;
   logic [COUNT_WIDTH-1:0] cnt_hold_q;

   logic                   pix_acc;
   logic                   rd_issue;
   logic [COUNT_WIDTH-1:0] s1_base;
   logic [COUNT_WIDTH-1:0] s1_inc;
   logic                   mem_we;
   logic [DATA_WIDTH-1:0]  mem_waddr;
   logic [COUNT_WIDTH-1:0] mem_wdata;
   logic                   mem_re;
   logic [DATA_WIDTH-1:0]  mem_raddr;

   assign pix_acc  = valid_i_hist && (state_q == S_ACCUM);
   assign rd_issue = (state_q == S_READOUT) && rd_en_i_hist && !rd_last_q;

   // The read for stage 1 was sampled on the same edge stage 2 wrote, so it misses that write.
   assign s1_base = (s2_vld_q && (s2_addr_q == s1_addr_q)) ? s2_cnt_q : mem_rdata_q;
   assign s1_inc  = s1_base + COUNT_WIDTH'(1);

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = s1_addr_q;
      mem_wdata = s1_inc;
      if (state_q == S_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_ptr_q;
         mem_wdata = '0;
      end else if (s1_vld_q) begin
         mem_we    = 1'b1;
      end
   end

   always_comb begin
      mem_re    = pix_acc || rd_issue;
      mem_raddr = pix_acc ? data_i_hist : rd_ptr_q;
   end

   always_comb begin
      state_d     = state_q;
      clr_ptr_d   = clr_ptr_q;
      pix_cnt_d   = pix_cnt_q;
      flush_cnt_d = flush_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      rd_last_d   = rd_last_q;
      case (state_q)
         S_IDLE: begin
            if (en_i_hist) begin
               state_d     = S_CLEAR;
               clr_ptr_d   = '0;
               pix_cnt_d   = '0;
               flush_cnt_d = 1'b0;
               rd_ptr_d    = '0;
               rd_last_d   = 1'b0;
            end
         end
         S_CLEAR: begin
            clr_ptr_d = clr_ptr_q + DATA_WIDTH'(1);
            if (clr_ptr_q == LAST_BIN) begin
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (pix_acc) begin
               pix_cnt_d = pix_cnt_q + COUNT_WIDTH'(1);
               if (pix_cnt_q == LAST_PIX) begin
                  state_d     = S_FLUSH;
                  flush_cnt_d = 1'b0;
               end
            end
         end
         S_FLUSH: begin
            flush_cnt_d = 1'b1;
            if (flush_cnt_q) begin
               state_d  = S_READOUT;
               rd_ptr_d = '0;
            end
         end
         S_READOUT: begin
            // Stay one extra cycle after the last issue so done lines up with its data.
            if (rd_last_q) begin
               state_d   = S_IDLE;
               rd_last_d = 1'b0;
            end else if (rd_issue) begin
               if (rd_ptr_q == LAST_BIN) begin
                  rd_last_d = 1'b1;
               end else begin
                  rd_ptr_d = rd_ptr_q + DATA_WIDTH'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i_hist) begin
      if (!rstn_i_hist) begin
         state_q     <= S_IDLE;
         clr_ptr_q   <= '0;
         pix_cnt_q   <= '0;
         flush_cnt_q <= 1'b0;
         rd_ptr_q    <= '0;
         rd_last_q   <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_addr_q   <= '0;
         s2_vld_q    <= 1'b0;
         s2_addr_q   <= '0;
         s2_cnt_q    <= '0;
         out_vld_q   <= 1'b0;
         done_q      <= 1'b0;
         out_bin_q   <= '0;
         cnt_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         pix_cnt_q   <= pix_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_last_q   <= rd_last_d;
         s1_vld_q    <= pix_acc;
         if (pix_acc) begin
            s1_addr_q <= data_i_hist;
         end
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            s2_addr_q <= s1_addr_q;
            s2_cnt_q  <= s1_inc;
         end
         out_vld_q <= rd_issue;
         done_q    <= rd_issue && (rd_ptr_q == LAST_BIN);
         if (rd_issue) begin
            out_bin_q <= rd_ptr_q;
         end
         if (out_vld_q) begin
            cnt_hold_q <= mem_rdata_q;
         end
      end
   end

   // Bin storage carries no reset; CLEAR initialises it every frame.
   always_ff @(posedge clk_i_hist) begin
      if (mem_we) begin
         bin_mem_q[mem_waddr] <= mem_wdata;
      end
      if (mem_re) begin
         mem_rdata_q <= bin_mem_q[mem_raddr];
      end
   end

   assign ready_o_hist = (state_q == S_ACCUM);
   assign busy_o_hist  = (state_q != S_IDLE);
   assign valid_o_hist = out_vld_q;
   assign done_o_hist  = done_q;
   assign bin_o_hist   = out_bin_q;
   assign count_o_hist = out_vld_q ? mem_rdata_q : cnt_hold_q;

endmodule

// File: tb/tb_histogram_calc.sv
// Randomised frame-level bench for histogram_calc against an array-count reference histogram.
module tb_histogram_calc;

   localparam int DW = 8;
   localparam int RD = 600;
   localparam int BC = 2**DW;
   localparam int CW = $clog2(RD+1);

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          en = 1'b0;
   logic          valid = 1'b0;
   logic [DW-1:0] data = '0;
   logic          rd_en = 1'b0;
   logic          ready, busy, valid_o, done_o;
   logic [DW-1:0] bin_o;
   logic [CW-1:0] count_o;

   int n_chk = 0;
   int n_err = 0;
   int cur_frame = -1;
   int model [BC];
   int stress [16] = '{5,5,5,7,5,7,7,5,9,9,5,5,7,9,5,5};
   int trio [3] = '{5,7,9};

   always #5 clk = ~clk;

   histogram_calc #(
      .DATA_WIDTH (DW),
      .RAM_DEPTH  (RD),
      .BIN_COUNT  (BC),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk_i_hist  (clk),
      .rstn_i_hist (rstn),
      .en_i_hist   (en),
      .valid_i_hist(valid),
      .data_i_hist (data),
      .rd_en_i_hist(rd_en),
      .ready_o_hist(ready),
      .busy_o_hist (busy),
      .bin_o_hist  (bin_o),
      .count_o_hist(count_o),
      .valid_o_hist(valid_o),
      .done_o_hist (done_o)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s (frame %0d): got %0d expected %0d", tag, cur_frame, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Modes: 0 zeros, 1 ramp, 2 forwarding stress, 3 handshake gaps, 4 all-threes, 5 random with stray en
   task automatic run_frame(input int mode);
      int acc, k, d, rc, exp_bin, first_v, run, maxrun, dones, sum;
      int lastb, lastc;
      bit v;
      cur_frame = mode;
      for (int b = 0; b < BC; b++) model[b] = 0;
      en = 1'b1;
      valid = 1'b0;
      tick();
      en = 1'b0;
      for (int c = 1; c <= BC; c++) begin
         if (c == 1) begin
            chk("busy_clear_start", busy, 1);
            chk("ready_clear_start", ready, 0);
         end
         if (c == BC) chk("ready_clear_end", ready, 0);
         if (mode == 3) begin
            valid = 1'($urandom_range(0, 1));
            data  = DW'($urandom_range(0, BC-1));
         end
         tick();
      end
      valid = 1'b0;
      chk("ready_accum_start", ready, 1);
      acc = 0;
      k = 0;
      while (acc < RD && k < 20*RD) begin
         v = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
         case (mode)
            0:       d = 0;
            1:       d = acc % BC;
            2:       d = (acc < 16) ? stress[acc] : trio[$urandom_range(0, 2)];
            4:       d = 3;
            default: d = $urandom_range(0, BC-1);
         endcase
         en    = (mode == 5) && (k % 50 == 7);
         valid = v;
         data  = DW'(d);
         if (v) begin
            model[d]++;
            acc++;
         end
         k++;
         tick();
      end
      en = 1'b0;
      chk("accum_pixels", acc, RD);
      valid = (mode == 3);
      data  = DW'($urandom_range(0, BC-1));
      chk("ready_flush", ready, 0);
      chk("busy_flush", busy, 1);
      tick();
      tick();
      valid = 1'b0;
      rc = 0; exp_bin = 0; first_v = -1; run = 0; maxrun = 0; dones = 0; sum = 0;
      lastb = 0; lastc = 0;
      while (exp_bin < BC && rc < 4*BC) begin
         if (valid_o) begin
            if (first_v < 0) first_v = rc;
            chk("bin_order", bin_o, exp_bin);
            chk("bin_count", count_o, model[exp_bin]);
            chk("done_flag", done_o, (exp_bin == BC-1));
            sum += int'(count_o);
            run++;
            if (run > maxrun) maxrun = run;
            lastb = int'(bin_o);
            lastc = int'(count_o);
            exp_bin++;
         end else begin
            run = 0;
            if (exp_bin > 0) begin
               chk("hold_bin", bin_o, lastb);
               chk("hold_count", count_o, lastc);
            end
         end
         if (done_o) dones++;
         rd_en = (mode == 3) ? (rc % 2 == 0) : 1'b1;
         tick();
         rc++;
      end
      rd_en = 1'b0;
      chk("readout_bins_seen", exp_bin, BC);
      chk("readout_latency", first_v, 1);
      if (mode != 3) chk("valid_run", maxrun, BC);
      chk("count_sum", sum, RD);
      chk("done_pulses", dones, 1);
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid_o, 0);
      chk("idle_done", done_o, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      repeat (3) tick();
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_bin", bin_o, 0);
      chk("rst_count", count_o, 0);
      rstn = 1'b1;
      tick();

      run_frame(0);
      run_frame(1);
      run_frame(2);
      run_frame(3);

      cur_frame = 10;
      en = 1'b1;
      tick();
      en = 1'b0;
      repeat (BC) tick();
      valid = 1'b1;
      data  = DW'(200);
      repeat (100) tick();
      valid = 1'b0;
      rstn  = 1'b0;
      tick();
      rstn  = 1'b1;
      chk("midrst_ready", ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", valid_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_bin", bin_o, 0);
      chk("midrst_count", count_o, 0);

      run_frame(4);
      run_frame(5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
